// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin valid/ready arbiter sharing one combinational ALU
// Holds the granted operands on the ALU inputs and returns the registered result to the owner.
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MULDIV_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [3:0]       req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zf,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zf,
  output logic             busy
);

  localparam int CW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(MULDIV_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       sel_q;
  logic [WIDTH-1:0] res_q;
  logic             zf_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             idle;
  logic             owner_ready;

  function automatic logic [CW-1:0] wait_for(input logic [3:0] sel);
    return (sel == 4'b0010 || sel == 4'b0011) ? WAIT_LD : '0;
  endfunction

  assign idle = (state_q == S_IDLE);

  // last_grant_q names the requester that lost priority; the other one wins a tie.
  assign req0_ready = idle && req0_valid && (!req1_valid || last_grant_q);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant_q);

  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      sel_q        <= '0;
      res_q        <= '0;
      zf_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_ready) begin
            x_q          <= req0_x;
            y_q          <= req0_y;
            sel_q        <= req0_sel;
            cnt_q        <= wait_for(req0_sel);
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            state_q      <= S_EXEC;
          end else if (req1_ready) begin
            x_q          <= req1_x;
            y_q          <= req1_y;
            sel_q        <= req1_sel;
            cnt_q        <= wait_for(req1_sel);
            owner_q      <= 1'b1;
            last_grant_q <= 1'b1;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            res_q        <= alu_res;
            zf_q         <= alu_zf;
            rsp0_valid_q <= !owner_q;
            rsp1_valid_q <= owner_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (owner_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign alu_sel    = sel_q;
  assign rsp_res    = res_q;
  assign rsp_zf     = zf_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_res, alu_x, alu_y, alu_res;
  logic        rsp_zf, alu_zf, busy;
  logic [3:0]  alu_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .MULDIV_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_zf(rsp_zf),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zf(alu_zf), .busy(busy)
  );

  // External ALU stand-in; undefined opcodes yield 0.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'b0000: alu_res = alu_x + alu_y;
      4'b0001: alu_res = alu_x - alu_y;
      4'b0010: alu_res = alu_x * alu_y;
      4'b0011: alu_res = (alu_y != 0) ? alu_x / alu_y : 32'd0;
      4'b0100: alu_res = alu_x & alu_y;
      4'b0101: alu_res = alu_x | alu_y;
      4'b0110: alu_res = alu_x ^ alu_y;
      default: alu_res = '0;
    endcase
  end
  assign alu_zf = (alu_res == 32'd0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int who, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] sel, input logic [31:0] exp_res,
                        input logic exp_zf, input int exp_lat);
    int  k;
    bit  got;
    if (who == 0) begin
      req0_x = x; req0_y = y; req0_sel = sel; req0_valid = 1'b1;
    end else begin
      req1_x = x; req1_y = y; req1_sel = sel; req1_valid = 1'b1;
    end
    #1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((who == 0) ? req0_ready : req1_ready) got = 1;
      else step();
    end
    check($sformatf("accept%0d", who), got, 1);
    check("single_ready", req0_ready & req1_ready, 0);
    step();
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    k = 1;
    while (!((who == 0) ? rsp0_valid : rsp1_valid) && k < 20) begin
      check("alu_x_hold", alu_x, x);
      check("alu_y_hold", alu_y, y);
      check("alu_sel_hold", alu_sel, sel);
      check("busy_exec", busy, 1);
      step();
      k++;
    end
    check("latency", k, exp_lat);
    check("rsp_res", rsp_res, exp_res);
    check("rsp_zf", rsp_zf, exp_zf);
    check("other_valid", (who == 0) ? rsp1_valid : rsp0_valid, 0);
    if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("idle_after_rsp", busy, 0);
    check("valid_cleared", rsp0_valid | rsp1_valid, 0);
  endtask

  initial begin
    int n, cyc, last_cyc;
    int gl[4];

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_x = 0; req0_y = 0; req0_sel = 0; req1_x = 0; req1_y = 0; req1_sel = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_rdy", {req0_ready, req1_ready}, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_res", rsp_res, 0);
    check("rst_zf", rsp_zf, 0);
    check("rst_alu", {alu_x, alu_y, 28'd0, alu_sel}, 0);
    step();
    rst_n = 1'b1;
    step();

    run_op(0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 2);
    run_op(1, 32'd9, 32'd9, 4'b0001, 32'd0, 1'b1, 2);
    run_op(0, 32'd100, 32'd7, 4'b0011, 32'd14, 1'b0, 5);
    run_op(1, 32'd6, 32'd7, 4'b0010, 32'd42, 1'b0, 5);
    run_op(0, 32'd3, 32'd5, 4'b1100, 32'd0, 1'b1, 2);
    run_op(1, 32'hF0, 32'h0F, 4'b0111, 32'd0, 1'b1, 2);

    // Backpressure with a competing request and a non-owner ready that must be ignored.
    req0_x = 3; req0_y = 4; req0_sel = 4'b0000; req0_valid = 1'b1;
    #1;
    check("bp_accept", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    step();
    check("bp_rsp_valid", rsp0_valid, 1);
    req1_x = 1; req1_y = 1; req1_sel = 4'b0000; req1_valid = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", rsp0_valid, 1);
      check("bp_hold_res", rsp_res, 7);
      check("bp_no_ready", {req0_ready, req1_ready}, 0);
      check("bp_busy", busy, 1);
      step();
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("bp_idle", busy, 0);
    check("bp_valid_drop", rsp0_valid, 0);
    check("bp_waiter_ready", req1_ready, 1);
    run_op(1, 32'd1, 32'd1, 4'b0000, 32'd2, 1'b0, 2);

    // Reset in the middle of a MUL window.
    req1_x = 6; req1_y = 7; req1_sel = 4'b0010; req1_valid = 1'b1;
    #1;
    check("mul_accept", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_alu", {alu_x, alu_y, 28'd0, alu_sel}, 0);
    check("arst_rsp", {rsp0_valid, rsp1_valid}, 0);
    check("arst_res", rsp_res, 0);
    req0_x = 10; req0_y = 3; req0_sel = 4'b0001; req0_valid = 1'b1;
    req1_x = 4; req1_y = 0; req1_sel = 4'b1100; req1_valid = 1'b1;
    step();
    check("arst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_r0", req0_ready, 1);
    check("post_rst_r1", req1_ready, 0);
    run_op(0, 32'd10, 32'd3, 4'b0001, 32'd7, 1'b0, 2);
    run_op(1, 32'd4, 32'd0, 4'b1100, 32'd0, 1'b1, 2);

    // Contention from reset: both valid, responses always accepted.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_x = 1; req0_y = 1; req0_sel = 4'b0000; req0_valid = 1'b1;
    req1_x = 2; req1_y = 2; req1_sel = 4'b0000; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    n = 0; cyc = 0; last_cyc = 0;
    while (n < 4 && cyc < 40) begin
      if (req0_ready | req1_ready) begin
        check("cont_one_ready", req0_ready & req1_ready, 0);
        gl[n] = int'(req1_ready);
        if (n > 0) check("cont_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        n++;
      end
      step();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_grants", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("cont_order%0d", i), gl[i], i % 2);
    step(); step(); step();
    check("cont_idle", busy, 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 32-bit ALU between two requesters (e.g. the integer pipe and a multi-cycle helper unit) using valid/ready handshakes. It registers the winning request's operands and opcode and holds them stable on the ALU inputs. Multiply/divide opcodes get a programmable multicycle settling window. The registered result and zero flag are returned to the owning requester.

## Interface
- WIDTH, 32, operand/result width
- MULDIV_WAIT, 3, extra EXEC cycles for sel 4'b0010 (MUL) and 4'b0011 (DIV); 0 = none
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready
- req0_x, req0_y / req1_x, req1_y  in  WIDTH  operands
- req0_sel / req1_sel  in  4  ALU opcode, passed through unmodified
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp_res  out  WIDTH  registered result, shared by both response channels
- rsp_zf  out  1  registered zero flag
- alu_x, alu_y  out  WIDTH  to ALU operand inputs
- alu_sel  out  4  to ALU opcode input
- alu_res  in  WIDTH  from ALU result
- alu_zf  in  1  from ALU zero flag
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: no request in flight.
    - If any reqN_valid, grant one requester and raise only its reqN_ready, combinationally from state, valids and pointer.
    - On handshake, load x/y/sel into the operand registers and record owner. Load wait counter = MULDIV_WAIT if sel is 0010/0011, else 0. Go to EXEC.
  - EXEC: operand registers drive alu_x/alu_y/alu_sel.
    - Counter nonzero: decrement.
    - Counter zero: capture alu_res into rsp_res and alu_zf into rsp_zf, go to RESP.
  - RESP: assert rsp{owner}_valid.
    - Hold it and rsp_res/rsp_zf stable until rsp{owner}_ready, then go to IDLE.
    - The non-owner rsp_ready is ignored.
- Arbitration: round-robin with a 1-bit last_grant pointer.
  - If both valid, grant the requester not granted last. If one valid, grant it.
  - The pointer updates only on a handshake.
- Both reqN_ready are 0 outside IDLE. Requesters must hold valid and data until accepted.
- Opcodes are not decoded beyond the MUL/DIV wait check. Undefined opcodes (0111, 1000, 11xx) pass through and return whatever the ALU produces (0, zf=1).
- Counter width is clog2(MULDIV_WAIT+1), minimum 1.

## Timing
- Reset values: state=IDLE, last_grant=1 (req0 wins first contention), operand registers 0, alu_x/alu_y/alu_sel=0, rsp_res=0, rsp_zf=0, all ready/valid outputs 0, busy=0.
- Handshake in cycle N:
  - EXEC from N+1.
  - Non-MUL/DIV: result captured at the end of N+1, rspN_valid high from N+2.
  - MUL/DIV: rspN_valid high from N+2+MULDIV_WAIT.
- rsp_ready in cycle M → IDLE at M+1; the next accept is possible in M+1.
  - Peak throughput is one op per 3 cycles.
- alu_x/alu_y/alu_sel change only on a handshake edge. They are stable for the whole EXEC window and hold their last value afterwards.
- Simultaneous events:
  - Both valid in IDLE → exactly one ready.
  - rsp_ready and a new req_valid in the same RESP cycle → the request waits until IDLE.
- rst_n asserted mid-EXEC or mid-RESP: in-flight op dropped with no response, all outputs go to reset values immediately (asynchronous). The first op after reset goes to req0 if both are valid.
- valid without ready never changes state.

## Test plan
- Single ADD on req0: x=5, y=7, sel=0000 → handshake cycle N, rsp0_valid at N+2, rsp_res=12, rsp_zf=0; rsp1_valid stays 0.
- SUB to zero on req1: x=9, y=9, sel=0001 → rsp1_valid at N+2, rsp_res=0, rsp_zf=1.
- DIV with MULDIV_WAIT=3: x=100, y=7, sel=0011 → rsp_valid at N+5, rsp_res=14. alu_x/alu_y/alu_sel are constant from N+1 through N+4.
- Contention: both valid continuously for 4 ops, rsp_ready tied 1 → grants alternate req0, req1, req0, req1 at 3-cycle spacing.
- Backpressure: rsp0_ready low for 5 cycles in RESP → rsp0_valid and rsp_res held, req0_ready/req1_ready stay 0, busy=1; release → IDLE the next cycle.
- Reset in EXEC of a MUL: rst_n low mid-window → all outputs 0 asynchronously, no rsp_valid. After release with both valid, req0 is granted first.
